// File: rtl/uart_rx_loader.sv
// Purpose: 8N1 serial receiver feeding the program-load byte write port, with byte count, framing error and idle-done pulse.
// Latency: rx falling edge -> START after 3 clocks; w_uart strobes at start edge + HALF + 9*CPB.
// Backpressure: none; every accepted byte is a one-cycle strobe that the write port must take.
module uart_rx_loader #(
   parameter int CLK_HZ  = 27_000_000,
   parameter int BAUD    = 115200,
   parameter int CPB     = CLK_HZ / BAUD,
   parameter int HALF    = CPB / 2,
   parameter int IDLE_TO = 2_700_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx,
   output logic        w_uart,
   output logic [7:0]  dat_uart,
   output logic        frame_err,
   output logic [13:0] byte_cnt,
   output logic        rx_busy,
   output logic        load_done
);

   localparam int CW = (CPB > 1) ? $clog2(CPB) : 1;
   localparam int TW = (IDLE_TO > 1) ? $clog2(IDLE_TO) : 1;
   localparam logic [CW-1:0] C_LAST = CW'(CPB - 1);
   localparam logic [CW-1:0] C_HALF = CW'(HALF - 1);
   localparam logic [TW-1:0] T_LAST = TW'(IDLE_TO - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t        r_state;
   logic          r_sync1;
   logic          r_rx_s;
   logic          r_rx_d;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_bit_idx;
   logic [7:0]    r_shreg;
   logic [TW-1:0] r_timer;
   logic          r_armed;
   logic          r_w_uart;
   logic [7:0]    r_dat_uart;
   logic          r_frame_err;
   logic [13:0]   r_byte_cnt;
   logic          r_load_done;
   logic          w_fall;

   // Two-flop synchronizer plus one delay flop for edge detection; all idle high so reset never fakes an edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync1 <= 1'b1;
         r_rx_s  <= 1'b1;
         r_rx_d  <= 1'b1;
      end else begin
         r_sync1 <= rx;
         r_rx_s  <= r_sync1;
         r_rx_d  <= r_rx_s;
      end
   end

   // Only a genuine high-to-low transition can open a frame; a line stuck low is ignored.
   assign w_fall = r_rx_d & ~r_rx_s;

   // Receive FSM, idle timer and all registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_bit_idx   <= '0;
         r_shreg     <= '0;
         r_timer     <= '0;
         r_armed     <= 1'b0;
         r_w_uart    <= 1'b0;
         r_dat_uart  <= '0;
         r_frame_err <= 1'b0;
         r_byte_cnt  <= '0;
         r_load_done <= 1'b0;
      end else begin
         r_w_uart    <= 1'b0;
         r_frame_err <= 1'b0;
         r_load_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_fall) begin
                  // Leaving IDLE restarts the idle window from scratch on the next return.
                  r_state <= S_START;
                  r_cnt   <= '0;
                  r_timer <= '0;
               end else if (r_armed) begin
                  if (r_timer == T_LAST) begin
                     r_load_done <= 1'b1;
                     r_armed     <= 1'b0;
                     r_byte_cnt  <= '0;
                     r_timer     <= '0;
                  end else begin
                     r_timer <= r_timer + TW'(1);
                  end
               end
            end
            S_START: begin
               if (r_cnt == C_HALF) begin
                  r_cnt <= '0;
                  if (!r_rx_s) begin
                     r_state   <= S_DATA;
                     r_bit_idx <= '0;
                  end else begin
                     // Line already back high at mid start bit: a glitch, drop it silently.
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_DATA: begin
               if (r_cnt == C_LAST) begin
                  r_shreg   <= {r_rx_s, r_shreg[7:1]};
                  r_cnt     <= '0;
                  r_bit_idx <= r_bit_idx + 3'd1;
                  if (r_bit_idx == 3'd7) begin
                     r_state <= S_STOP;
                  end
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_STOP: begin
               if (r_cnt == C_LAST) begin
                  r_cnt   <= '0;
                  r_state <= S_IDLE;
                  if (r_rx_s) begin
                     r_dat_uart <= r_shreg;
                     r_w_uart   <= 1'b1;
                     r_byte_cnt <= r_byte_cnt + 14'd1;
                     r_armed    <= 1'b1;
                  end else begin
                     r_frame_err <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign w_uart    = r_w_uart;
   assign dat_uart  = r_dat_uart;
   assign frame_err = r_frame_err;
   assign byte_cnt  = r_byte_cnt;
   assign rx_busy   = (r_state != S_IDLE);
   assign load_done = r_load_done;

endmodule
